// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS decode/execute slice.
package mips_pkg;

    localparam int WORD_WIDTH = 32;

    // Main opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALU operation codes, MIPS funct encoding
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALUOp encodings from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // Datapath control bundle produced by the main decoder
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // Sign-extend a 16-bit immediate to the datapath width
    function automatic logic [WORD_WIDTH-1:0] sign_ext16(input logic [15:0] imm);
        return {{(WORD_WIDTH-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU: A/B/funct/shamt -> result, zero.
module alu_core
    import mips_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    input  logic [5:0]            funct,
    input  logic [4:0]            shamt,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  zero
);

    logic [WORD_WIDTH-1:0] result_s;

    // Select the operation; shifts act on B only, unsupported codes give 0
    always_comb begin
        result_s = {WORD_WIDTH{1'b0}};
        case (funct)
            FN_ADD, FN_ADDU: result_s = a + b;
            FN_SUB, FN_SUBU: result_s = a - b;
            FN_AND:          result_s = a & b;
            FN_OR:           result_s = a | b;
            FN_XOR:          result_s = a ^ b;
            FN_NOR:          result_s = ~(a | b);
            FN_SLT:          result_s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            FN_SLTU:         result_s = (a < b) ? 32'd1 : 32'd0;
            FN_SLL:          result_s = b << shamt;
            FN_SRL:          result_s = b >> shamt;
            FN_SRA:          result_s = $unsigned($signed(b) >>> shamt);
            default:         result_s = {WORD_WIDTH{1'b0}};
        endcase
    end

    assign result = result_s;
    assign zero   = (result_s == {WORD_WIDTH{1'b0}});

endmodule

// File: rtl/decode_exec_unit.sv
// Main decoder, ALU-function decoder, operand-B mux and ALU with all
// outputs registered once on clk.
module decode_exec_unit
    import mips_pkg::*;
#(
    parameter int WORD_WIDTH = mips_pkg::WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic [WORD_WIDTH-1:0] rs_data,
    input  logic [WORD_WIDTH-1:0] rt_data,
    output logic                  reg_dst,
    output logic                  branch,
    output logic                  mem_read,
    output logic                  mem_to_reg,
    output logic                  mem_write,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic [1:0]            alu_op,
    output logic [5:0]            alu_funct,
    output logic [WORD_WIDTH-1:0] alu_result,
    output logic                  zero
);

    // Instruction fields
    logic [5:0]  opcode_s;
    logic [4:0]  shamt_s;
    logic [5:0]  funct_s;
    logic [15:0] imm_s;
    logic        unused_fields_s;

    assign opcode_s        = instr[31:26];
    assign shamt_s         = instr[10:6];
    assign funct_s         = instr[5:0];
    assign imm_s           = instr[15:0];
    // rs field is consumed by the register file, not here
    assign unused_fields_s = ^instr[25:21];

    ctrl_t                 ctrl_s;
    logic [5:0]            alu_funct_s;
    logic [WORD_WIDTH-1:0] op_b_s;
    logic [WORD_WIDTH-1:0] alu_result_s;
    logic                  zero_s;

    ctrl_t                 ctrl_r;
    logic [5:0]            alu_funct_r;
    logic [WORD_WIDTH-1:0] alu_result_r;
    logic                  zero_r;

    // Main decode: opcode -> datapath controls; unknown opcodes are inert adds
    always_comb begin
        ctrl_s = '0;
        case (opcode_s)
            OP_RTYPE: begin
                ctrl_s.reg_dst   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_read   = 1'b1;
                ctrl_s.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.mem_write = 1'b1;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl_s.branch = 1'b1;
                ctrl_s.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            default: begin
                ctrl_s = '0;
            end
        endcase
    end

    // ALU-function decode: fixed add/sub or funct pass-through for R-type
    always_comb begin
        alu_funct_s = FN_ADD;
        case (ctrl_s.alu_op)
            ALUOP_ADD:   alu_funct_s = FN_ADD;
            ALUOP_SUB:   alu_funct_s = FN_SUB;
            ALUOP_FUNCT: alu_funct_s = funct_s;
            ALUOP_RSVD:  alu_funct_s = FN_ADD;
            default:     alu_funct_s = FN_ADD;
        endcase
    end

    // Operand B: sign-extended immediate or second register operand
    always_comb begin
        if (ctrl_s.alu_src) begin
            op_b_s = sign_ext16(imm_s);
        end else begin
            op_b_s = rt_data;
        end
    end

    alu_core u_alu_core (
        .a      (rs_data),
        .b      (op_b_s),
        .funct  (alu_funct_s),
        .shamt  (shamt_s),
        .result (alu_result_s),
        .zero   (zero_s)
    );

    // Output register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r       <= '0;
            alu_funct_r  <= 6'h00;
            alu_result_r <= {WORD_WIDTH{1'b0}};
            zero_r       <= 1'b0;
        end else begin
            ctrl_r       <= ctrl_s;
            alu_funct_r  <= alu_funct_s;
            alu_result_r <= alu_result_s;
            zero_r       <= zero_s;
        end
    end

    assign reg_dst    = ctrl_r.reg_dst;
    assign alu_src    = ctrl_r.alu_src;
    assign mem_to_reg = ctrl_r.mem_to_reg;
    assign reg_write  = ctrl_r.reg_write;
    assign mem_read   = ctrl_r.mem_read;
    assign mem_write  = ctrl_r.mem_write;
    assign branch     = ctrl_r.branch;
    assign alu_op     = ctrl_r.alu_op;
    assign alu_funct  = alu_funct_r;
    assign alu_result = alu_result_r;
    assign zero       = zero_r;

endmodule

// File: tb/tb_decode_exec_unit.sv
// Directed self-checking bench for decode_exec_unit.
module tb_decode_exec_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [5:0]  alu_funct;
    logic [31:0] alu_result;
    logic        zero;

    int total = 0;
    int bad   = 0;

    decode_exec_unit dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .reg_dst    (reg_dst),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .alu_funct  (alu_funct),
        .alu_result (alu_result),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [5:0] fn, input logic [4:0] sh);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // controls packed as reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op
    function automatic logic [8:0] ctrl_now();
        return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
    endfunction

    task automatic step(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        instr   = i;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
        step(mk_r(6'h20, 5'd0), 32'd5, 32'd7);
        chk("reset_ctrl",   {23'd0, ctrl_now()}, 32'h0);
        chk("reset_result", alu_result, 32'h0);
        chk("reset_funct",  {26'd0, alu_funct}, 32'h0);
        rst = 1'b0;

        // add
        step(mk_r(6'h20, 5'd0), 32'd5, 32'd7);
        chk("add_result", alu_result, 32'd12);
        chk("add_zero",   {31'd0, zero}, 32'd0);
        chk("add_ctrl",   {23'd0, ctrl_now()}, {23'd0, 9'b1_0_0_1_0_0_0_10});
        chk("add_funct",  {26'd0, alu_funct}, 32'h20);

        // sub to zero
        step(mk_r(6'h22, 5'd0), 32'h1234, 32'h1234);
        chk("sub_result", alu_result, 32'h0);
        chk("sub_zero",   {31'd0, zero}, 32'd1);

        // beq
        step(mk_i(6'h04, 16'h0010), 32'd3, 32'd3);
        chk("beq_ctrl",  {23'd0, ctrl_now()}, {23'd0, 9'b0_0_0_0_0_0_1_01});
        chk("beq_zero",  {31'd0, zero}, 32'd1);
        chk("beq_funct", {26'd0, alu_funct}, 32'h22);

        // lw with negative offset
        step(mk_i(6'h23, 16'hFFFC), 32'h100, 32'hDEAD);
        chk("lw_result", alu_result, 32'hFC);
        chk("lw_ctrl",   {23'd0, ctrl_now()}, {23'd0, 9'b0_1_1_1_1_0_0_00});
        chk("lw_funct",  {26'd0, alu_funct}, 32'h20);

        // sw
        step(mk_i(6'h2B, 16'h0008), 32'h20, 32'h5555);
        chk("sw_result", alu_result, 32'h28);
        chk("sw_ctrl",   {23'd0, ctrl_now()}, {23'd0, 9'b0_1_0_0_0_1_0_00});

        // addi wrapping to zero
        step(mk_i(6'h08, 16'hFFFF), 32'd1, 32'd9);
        chk("addi_result", alu_result, 32'h0);
        chk("addi_zero",   {31'd0, zero}, 32'd1);
        chk("addi_ctrl",   {23'd0, ctrl_now()}, {23'd0, 9'b0_1_0_1_0_0_0_00});

        // signed vs unsigned compare
        step(mk_r(6'h2A, 5'd0), 32'hFFFFFFFF, 32'd1);
        chk("slt_result", alu_result, 32'd1);
        step(mk_r(6'h2B, 5'd0), 32'hFFFFFFFF, 32'd1);
        chk("sltu_result", alu_result, 32'd0);
        chk("sltu_zero",   {31'd0, zero}, 32'd1);

        // shifts (A ignored)
        step(mk_r(6'h03, 5'd4), 32'h55, 32'h80000000);
        chk("sra_result", alu_result, 32'hF8000000);
        step(mk_r(6'h02, 5'd4), 32'h55, 32'h80000000);
        chk("srl_result", alu_result, 32'h08000000);
        step(mk_r(6'h00, 5'd4), 32'h55, 32'h0000000F);
        chk("sll_result", alu_result, 32'hF0);

        // logic ops
        step(mk_r(6'h27, 5'd0), 32'h0, 32'h0);
        chk("nor_result", alu_result, 32'hFFFFFFFF);
        chk("nor_zero",   {31'd0, zero}, 32'd0);
        step(mk_r(6'h24, 5'd0), 32'hF0F0, 32'hFF00);
        chk("and_result", alu_result, 32'hF000);
        step(mk_r(6'h25, 5'd0), 32'hF0F0, 32'hFF00);
        chk("or_result", alu_result, 32'hFFF0);
        step(mk_r(6'h26, 5'd0), 32'hF0F0, 32'hFF00);
        chk("xor_result", alu_result, 32'h0FF0);

        // unsupported funct passes through, result 0
        step(mk_r(6'h3F, 5'd0), 32'd5, 32'd7);
        chk("badfn_result", alu_result, 32'h0);
        chk("badfn_funct",  {26'd0, alu_funct}, 32'h3F);
        chk("badfn_zero",   {31'd0, zero}, 32'd1);

        // mid-stream reset
        rst = 1'b1;
        step(mk_r(6'h20, 5'd0), 32'd5, 32'd7);
        chk("midrst_ctrl",   {23'd0, ctrl_now()}, 32'h0);
        chk("midrst_result", alu_result, 32'h0);
        chk("midrst_zero",   {31'd0, zero}, 32'd0);
        chk("midrst_funct",  {26'd0, alu_funct}, 32'h0);

        // release reset with illegal opcode: inert add of rs+rt
        rst = 1'b0;
        step(mk_i(6'h3F, 16'h0004), 32'h10, 32'h20);
        chk("illegal_ctrl",   {23'd0, ctrl_now()}, 32'h0);
        chk("illegal_funct",  {26'd0, alu_funct}, 32'h20);
        chk("illegal_result", alu_result, 32'h30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_exec_unit.md
Name: decode_exec_unit

Overview:
- Combined main-control decoder, ALU-function decoder and 32-bit ALU for the single-cycle MIPS core.
- Takes the fetched instruction word and the two register-file read values.
- Produces the datapath control signals, the ALU result and the zero flag, all registered once on clk.
- Sits between RegFile (operand source) and DM / write-back mux (consumers).

Parameters:
- WORD_WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- instr  input  32  instruction word. opcode=[31:26], rt=[20:16], shamt=[10:6], funct=[5:0], imm=[15:0]
- rs_data  input  32  register-file read port 1 (ALU operand A)
- rt_data  input  32  register-file read port 2
- reg_dst  output  1  1 = write rd, 0 = write rt
- branch  output  1  beq in execute
- mem_read  output  1  DM read enable
- mem_to_reg  output  1  write-back selects DM data
- mem_write  output  1  DM write enable
- alu_src  output  1  1 = operand B is the sign-extended immediate
- reg_write  output  1  register-file write enable
- alu_op  output  2  00 add, 01 sub, 10 use funct, 11 reserved
- alu_funct  output  6  resolved ALU operation code (MIPS funct encoding)
- alu_result  output  32  ALU result
- zero  output  1  1 when the combinational ALU result is 0

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - All outputs are registered. Values computed from instr/rs_data/rt_data appear after the next rising clk edge (latency 1). No handshake; a new instruction is accepted every cycle.
  - rst=1 at a rising edge clears every output to 0. This overrides the inputs and applies mid-stream. The first non-reset edge loads normal values.
- Main decode (controls listed as reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op):
  - 0x00 R-type: 1,0,0,1,0,0,0,10
  - 0x23 lw: 0,1,1,1,1,0,0,00
  - 0x2B sw: 0,1,0,0,0,1,0,00
  - 0x04 beq: 0,0,0,0,0,0,1,01
  - 0x08 addi: 0,1,0,1,0,0,0,00
  - Any other opcode: all controls 0 and alu_op=00. The datapath still computes an add with operand B=rt_data.
- ALU-function decode:
  - alu_op=00 gives 0x20 (add). alu_op=01 gives 0x22 (sub). alu_op=11 gives 0x20.
  - alu_op=10 passes funct through for the supported set: 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu, 0x00 sll, 0x02 srl, 0x03 sra.
  - Unsupported funct is passed through and gives result 0.
- Operands:
  - A = rs_data.
  - B = alu_src ? {{16{imm[15]}},imm} : rt_data.
- ALU:
  - All arithmetic is modulo 2^32. No overflow trap; add and addu are identical, as are sub and subu.
  - slt: signed compare, result 1 or 0.
  - sltu: unsigned compare.
  - Shifts shift B by shamt; A is ignored. sra sign-fills.
  - zero is computed from the same-cycle result and registered with it.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI)
  - funct constants (FN_ADD … FN_SRA)
  - ALUOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
  - WORD_WIDTH
- One sub-module is natural: alu_core, a purely combinational A/B/funct/shamt → result, zero block.
- The main decode, ALU-function decode, operand-B mux and output register stay in decode_exec_unit.

Test Plan:
- Add: R-type funct 0x20, rs_data=5, rt_data=7 → after 1 edge alu_result=12, zero=0, reg_dst=1, reg_write=1, alu_op=10, alu_funct=0x20.
- Sub to zero, then beq:
  - R-type sub with rs_data=rt_data=0x1234 → alu_result=0, zero=1.
  - beq (0x04) with rs_data=rt_data=3 → branch=1, zero=1, alu_funct=0x22, reg_write=0.
- lw with negative offset: opcode 0x23, imm=0xFFFC, rs_data=0x100 → alu_result=0xFC, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, reg_dst=0.
- Signed vs unsigned compare: slt with rs_data=0xFFFFFFFF, rt_data=1 → 1; sltu with the same operands → 0.
- Shifts and nor:
  - sra, shamt=4, rt_data=0x80000000 → 0xF8000000.
  - nor with 0 and 0 → 0xFFFFFFFF, zero=0.
- Reset and illegal opcode:
  - Assert rst during a valid R-type stream → all outputs 0 after that edge.
  - Deassert rst with opcode 0x3F → all controls 0.
